// File: rtl/sobel_edge_detect_8bit.sv
// Sobel gradient magnitude and thresholded edge map over a 3x3 window, fixed 4-stage pipeline.
// Define SOBEL_EDGE_COUNT_EN to add a per-frame edge-pixel counter (edge_count / edge_count_valid).
module sobel_edge_detect_8bit #(
  parameter logic [7:0] THRESH_DEFAULT = 8'd64,
  parameter int         CNT_WIDTH      = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 matrix_frame_vsync,
  input  logic                 matrix_frame_href,
  input  logic [7:0]           matrix_p11,
  input  logic [7:0]           matrix_p12,
  input  logic [7:0]           matrix_p13,
  input  logic [7:0]           matrix_p21,
  input  logic [7:0]           matrix_p22,
  input  logic [7:0]           matrix_p23,
  input  logic [7:0]           matrix_p31,
  input  logic [7:0]           matrix_p32,
  input  logic [7:0]           matrix_p33,
  input  logic [7:0]           Sobel_Threshold,
  output logic                 post_frame_vsync,
  output logic                 post_frame_href,
  output logic [7:0]           post_img_grad,
  output logic                 post_img_Bit
`ifdef SOBEL_EDGE_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] edge_count,
  output logic                 edge_count_valid
`endif
);

  if (CNT_WIDTH < 1) begin : g_cnt_width_check
    $error("CNT_WIDTH must be at least 1");
  end

  logic [3:0]  vs_q, vs_d;
  logic [3:0]  hs_q, hs_d;
  logic [7:0]  thr_q, thr_d;

  logic [9:0]  gx_pos_q, gx_pos_d;
  logic [9:0]  gx_neg_q, gx_neg_d;
  logic [9:0]  gy_pos_q, gy_pos_d;
  logic [9:0]  gy_neg_q, gy_neg_d;

  logic [9:0]  gx_abs_q, gx_abs_d;
  logic [9:0]  gy_abs_q, gy_abs_d;

  logic [10:0] mag_q, mag_d;

  logic [7:0]  grad_q, grad_d;
  logic        bit_q, bit_d;

  // p22 does not contribute to either Sobel kernel
  logic [7:0] unused_p22;
  assign unused_p22 = matrix_p22;

  always_comb begin
    vs_d  = {vs_q[2:0], matrix_frame_vsync};
    hs_d  = {hs_q[2:0], matrix_frame_href};
    thr_d = thr_q;
    if (matrix_frame_vsync && !vs_q[0]) begin
      thr_d = Sobel_Threshold;
    end

    // S1: positive/negative halves of each kernel, each <= 1020
    gx_pos_d = {2'b00, matrix_p13} + {1'b0, matrix_p23, 1'b0} + {2'b00, matrix_p33};
    gx_neg_d = {2'b00, matrix_p11} + {1'b0, matrix_p21, 1'b0} + {2'b00, matrix_p31};
    gy_pos_d = {2'b00, matrix_p11} + {1'b0, matrix_p12, 1'b0} + {2'b00, matrix_p13};
    gy_neg_d = {2'b00, matrix_p31} + {1'b0, matrix_p32, 1'b0} + {2'b00, matrix_p33};

    // S2: absolute difference without signed arithmetic
    gx_abs_d = (gx_pos_q >= gx_neg_q) ? (gx_pos_q - gx_neg_q) : (gx_neg_q - gx_pos_q);
    gy_abs_d = (gy_pos_q >= gy_neg_q) ? (gy_pos_q - gy_neg_q) : (gy_neg_q - gy_pos_q);

    mag_d = {1'b0, gx_abs_q} + {1'b0, gy_abs_q};

    // S4: gate on the href that lands alongside this data so blanking garbage never escapes
    grad_d = 8'd0;
    bit_d  = 1'b0;
    if (hs_q[2]) begin
      grad_d = (mag_q > 11'd255) ? 8'hFF : mag_q[7:0];
      bit_d  = (mag_q > {3'b000, thr_q});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q     <= '0;
      hs_q     <= '0;
      thr_q    <= THRESH_DEFAULT;
      gx_pos_q <= '0;
      gx_neg_q <= '0;
      gy_pos_q <= '0;
      gy_neg_q <= '0;
      gx_abs_q <= '0;
      gy_abs_q <= '0;
      mag_q    <= '0;
      grad_q   <= '0;
      bit_q    <= 1'b0;
    end else begin
      vs_q     <= vs_d;
      hs_q     <= hs_d;
      thr_q    <= thr_d;
      gx_pos_q <= gx_pos_d;
      gx_neg_q <= gx_neg_d;
      gy_pos_q <= gy_pos_d;
      gy_neg_q <= gy_neg_d;
      gx_abs_q <= gx_abs_d;
      gy_abs_q <= gy_abs_d;
      mag_q    <= mag_d;
      grad_q   <= grad_d;
      bit_q    <= bit_d;
    end
  end

  assign post_frame_vsync = vs_q[3];
  assign post_frame_href  = hs_q[3];
  assign post_img_grad    = grad_q;
  assign post_img_Bit     = bit_q;

`ifdef SOBEL_EDGE_COUNT_EN
  logic [CNT_WIDTH-1:0] run_q, run_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 cv_q, cv_d;
  logic                 vs_out_q, vs_out_d;
  logic [CNT_WIDTH-1:0] run_inc;
  logic                 vs_fall;

  always_comb begin
    vs_out_d = vs_q[3];
    vs_fall  = vs_out_q && !vs_q[3];
    run_inc  = run_q;
    if (hs_q[3] && bit_q && (run_q != {CNT_WIDTH{1'b1}})) begin
      run_inc = run_q + CNT_WIDTH'(1);
    end
    run_d = run_inc;
    cnt_d = cnt_q;
    cv_d  = 1'b0;
    // an edge pixel in the fall-detect cycle still belongs to the finished frame
    if (vs_fall) begin
      cnt_d = run_inc;
      cv_d  = 1'b1;
      run_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q    <= '0;
      cnt_q    <= '0;
      cv_q     <= 1'b0;
      vs_out_q <= 1'b0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      cv_q     <= cv_d;
      vs_out_q <= vs_out_d;
    end
  end

  assign edge_count       = cnt_q;
  assign edge_count_valid = cv_q;
`endif

endmodule
